// File: rtl/bypass_lane_arbiter_if.sv
// Result-source to bypass-lane bus: per-requester results in, registered lane packets out.
interface bypass_lane_arbiter_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned TAG_W     = 7,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CNT_W     = 16
);
  logic                          flush_i;
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ*TAG_W-1:0]      req_tag_i;
  logic [NUM_REQ*DATA_W-1:0]     req_data_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [NUM_LANES-1:0]          lane_valid_o;
  logic [NUM_LANES*TAG_W-1:0]    lane_tag_o;
  logic [NUM_LANES*DATA_W-1:0]   lane_data_o;
  logic [CNT_W-1:0]              conflict_cnt_o;

  modport master (
    output flush_i, req_valid_i, req_tag_i, req_data_i,
    input  req_ready_o, lane_valid_o, lane_tag_o, lane_data_o, conflict_cnt_o
  );

  modport slave (
    input  flush_i, req_valid_i, req_tag_i, req_data_i,
    output req_ready_o, lane_valid_o, lane_tag_o, lane_data_o, conflict_cnt_o
  );
endinterface

// File: rtl/bypass_lane_arbiter.sv
// Round-robin grant of up to NUM_LANES ready results per cycle onto registered bypass lanes,
// with a saturating count of oversubscribed cycles.
module bypass_lane_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned TAG_W     = 7,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  bypass_lane_arbiter_if.slave bus
);
  localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned LSEL_W = $clog2(NUM_LANES + 1);
  localparam int unsigned POP_W  = $clog2(NUM_REQ + 1);

  logic [PTR_W-1:0]     r_rr_ptr;
  logic [NUM_LANES-1:0] r_lane_valid;
  logic [TAG_W-1:0]     r_lane_tag  [NUM_LANES];
  logic [DATA_W-1:0]    r_lane_data [NUM_LANES];
  logic [CNT_W-1:0]     r_conflict_cnt;

  logic [TAG_W-1:0]     w_req_tag  [NUM_REQ];
  logic [DATA_W-1:0]    w_req_data [NUM_REQ];
  logic [NUM_REQ-1:0]   w_grant;
  logic [NUM_LANES-1:0] w_lane_hit;
  logic [PTR_W-1:0]     w_lane_src [NUM_LANES];
  logic [PTR_W-1:0]     w_rr_next;
  logic [LSEL_W-1:0]    w_n_grant;
  logic [POP_W-1:0]     w_pop;
  logic                 w_conflict;

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
    assign w_req_tag[r]  = bus.req_tag_i[r*TAG_W +: TAG_W];
    assign w_req_data[r] = bus.req_data_i[r*DATA_W +: DATA_W];
  end

  // Scan from rr_ptr with explicit wrap; k-th grant in scan order lands on lane k.
  always_comb begin
    w_grant    = '0;
    w_lane_hit = '0;
    w_rr_next  = r_rr_ptr;
    w_n_grant  = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) w_lane_src[k] = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      int unsigned      idx;
      logic [PTR_W-1:0] sel;
      idx = 32'(r_rr_ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = PTR_W'(idx);
      if (!bus.flush_i && bus.req_valid_i[sel] && (w_n_grant < LSEL_W'(NUM_LANES))) begin
        w_grant[sel] = 1'b1;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
          if (w_n_grant == LSEL_W'(k)) begin
            w_lane_hit[k] = 1'b1;
            w_lane_src[k] = sel;
          end
        end
        w_rr_next = (idx == NUM_REQ - 1) ? '0 : PTR_W'(idx + 1);
        w_n_grant = w_n_grant + LSEL_W'(1);
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) w_pop = w_pop + POP_W'(bus.req_valid_i[r]);
  end

  assign w_conflict = (w_pop > POP_W'(NUM_LANES)) && !bus.flush_i;

  // Grants are masked while reset is held so nothing is accepted and then lost.
  assign bus.req_ready_o = reset ? '0 : w_grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr       <= '0;
      r_lane_valid   <= '0;
      r_conflict_cnt <= '0;
      for (int unsigned k = 0; k < NUM_LANES; k++) begin
        r_lane_tag[k]  <= '0;
        r_lane_data[k] <= '0;
      end
    end else if (bus.flush_i) begin
      r_rr_ptr     <= '0;
      r_lane_valid <= '0;
    end else begin
      r_lane_valid <= w_lane_hit;
      for (int unsigned k = 0; k < NUM_LANES; k++) begin
        if (w_lane_hit[k]) begin
          r_lane_tag[k]  <= w_req_tag[w_lane_src[k]];
          r_lane_data[k] <= w_req_data[w_lane_src[k]];
        end
      end
      r_rr_ptr <= w_rr_next;
      if (w_conflict && (r_conflict_cnt != '1)) r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane_out
    assign bus.lane_tag_o[k*TAG_W +: TAG_W]    = r_lane_tag[k];
    assign bus.lane_data_o[k*DATA_W +: DATA_W] = r_lane_data[k];
  end

  assign bus.lane_valid_o   = r_lane_valid;
  assign bus.conflict_cnt_o = r_conflict_cnt;
endmodule
